qtz_segment_sched: RTL
======================

# qtz_segment_sched

Sequencer for the segmented quantized-level output registers. Walks every HV segment (outer loop) and every feature group (inner loop) of one sample: issues an item-memory fetch, waits the fixed fetch latency, strobes the one-hot segment select plus register enable so the selected segment register captures the fetched level HVs, then holds a valid flag until the downstream encoder accepts the group. Sits between the sample-level control FSM and the item-memory/segment-register datapath.

## Interface
- NUM_FEATURES, 617, features per sample
- FEATURES_PER_CC, 59, features fetched and registered per load
- NUM_SEGMENTS, 5, HV segments (each segment register is HV_DIM/NUM_SEGMENTS wide)
- FETCH_LAT, 2, cycles from im_req to fetch data stable at segment-register inputs; legal range 1..8
- Derived: NUM_GROUPS = ceil(NUM_FEATURES/FEATURES_PER_CC); SEG_W = clog2(NUM_SEGMENTS); GRP_W = clog2(NUM_GROUPS); CNT_W = clog2(FEATURES_PER_CC+1)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- start  in  1  begin one sample; honoured only in IDLE
- abort  in  1  synchronous abort, wins over all other inputs except rst
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after final group handshake
- im_req  out  1  one-cycle fetch strobe
- im_seg  out  SEG_W  segment index of current load
- im_group  out  GRP_W  feature-group index of current load
- seg_sel  out  NUM_SEGMENTS  one-hot segment select (drives each segment register's select input); zero outside LOAD
- qtz_out_reg_en  out  1  register capture enable, high only in LOAD
- grp_valid_cnt  out  CNT_W  valid features in current group
- lvl_valid  out  1  segment register holds an unconsumed group
- lvl_ready  in  1  downstream accepts group when lvl_valid && lvl_ready

## Operation
- States: IDLE, FETCH, WAIT, LOAD, HOLD.
- IDLE: start -> FETCH; seg=0, grp=0.
- FETCH (1 cycle): im_req=1. -> WAIT if FETCH_LAT>1, else -> LOAD.
- WAIT: exactly FETCH_LAT-1 cycles via down-counter, then -> LOAD.
- LOAD (1 cycle): qtz_out_reg_en=1, seg_sel=1<<seg. -> HOLD.
- HOLD: lvl_valid=1. On lvl_ready: if grp<NUM_GROUPS-1 then grp++; else grp=0, seg++. If this was seg=NUM_SEGMENTS-1, grp=NUM_GROUPS-1 -> IDLE with done=1 next cycle; otherwise -> FETCH.
- im_seg/im_group/grp_valid_cnt are stable from FETCH through HOLD of a load.
- grp_valid_cnt = FEATURES_PER_CC, except last group = NUM_FEATURES-(NUM_GROUPS-1)*FEATURES_PER_CC (27 with defaults).
- Counters wrap explicitly at NUM_GROUPS/NUM_SEGMENTS; no out-of-range index is ever driven.
- abort in any non-IDLE state: next cycle IDLE, counters cleared, lvl_valid=0, no done pulse. abort in IDLE: no effect.
- start while busy: ignored. lvl_ready outside HOLD: ignored.
- start coinciding with done cycle (state IDLE): accepted.

## Timing
- All outputs registered; reset values: busy=0, done=0, im_req=0, im_seg=0, im_group=0, seg_sel=0, qtz_out_reg_en=0, grp_valid_cnt=0, lvl_valid=0; state IDLE.
- rst mid-operation: outputs go to reset values immediately (async); no done.
- start sampled at cycle t -> im_req at t+1.
- im_req at cycle f -> qtz_out_reg_en at f+FETCH_LAT -> lvl_valid from f+FETCH_LAT+1.
- Per-load cost with lvl_ready held high: FETCH_LAT+2 cycles.
- Final handshake at cycle h -> done=1, busy=0 at h+1.
- Total with defaults and lvl_ready=1: 55 loads × 4 = 220 cycles.

## Test plan
- Defaults, start at cycle 0, lvl_ready=1 -> im_req at cycles 1,5,...,217; reg_en at 3,7,...,219; done only at 221; 55 reg_en pulses, seg_sel sequence 00001 ×11, 00010 ×11, ..., 10000 ×11.
- Same run -> grp_valid_cnt=59 for groups 0–9, 27 for group 10 in each segment; im_group wraps 10->0 as im_seg increments.
- lvl_ready low for 5 cycles in HOLD of seg 2/grp 4 -> lvl_valid held, no im_req, indices stable; schedule resumes 1 cycle after ready rises, done delayed by 5 cycles.
- FETCH_LAT=1 -> no WAIT state; reg_en exactly 1 cycle after im_req; 3 cycles/load, done at cycle 166.
- abort during WAIT of seg 1/grp 0, then start -> immediate IDLE, no done; next sample starts at seg 0/grp 0 and completes normally.
- rst asserted in HOLD, start pulsed while busy -> all outputs zero during rst; start while busy has no effect on sequence or counters.

Source files
------------

// File: rtl/qtz_segment_sched.sv
// qtz_segment_sched: walks segments x feature groups of one sample,
// fetching level HVs and loading them into the segment registers.
module qtz_segment_sched #(
    parameter int NUM_FEATURES    = 617,
    parameter int FEATURES_PER_CC = 59,
    parameter int NUM_SEGMENTS    = 5,
    parameter int FETCH_LAT       = 2,
    localparam int NUM_GROUPS =
        (NUM_FEATURES + FEATURES_PER_CC - 1) / FEATURES_PER_CC,
    localparam int SEG_W = $clog2(NUM_SEGMENTS),
    localparam int GRP_W = $clog2(NUM_GROUPS),
    localparam int CNT_W = $clog2(FEATURES_PER_CC + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic                    im_req,
    output logic [SEG_W-1:0]        im_seg,
    output logic [GRP_W-1:0]        im_group,
    output logic [NUM_SEGMENTS-1:0] seg_sel,
    output logic                    qtz_out_reg_en,
    output logic [CNT_W-1:0]        grp_valid_cnt,
    output logic                    lvl_valid,
    input  logic                    lvl_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_LOAD,
        S_HOLD
    } state_t;

    localparam int LAST_CNT =
        NUM_FEATURES - (NUM_GROUPS - 1) * FEATURES_PER_CC;
    localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(NUM_SEGMENTS - 1);
    localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(NUM_GROUPS - 1);
    localparam logic [3:0] WAIT_INIT =
        4'((FETCH_LAT > 1) ? (FETCH_LAT - 2) : 0);

    state_t                  state;
    state_t                  state_n;
    logic [SEG_W-1:0]        seg_n;
    logic [GRP_W-1:0]        grp_n;
    logic [3:0]              wcnt;
    logic [3:0]              wcnt_n;
    logic                    fin;
    logic [NUM_SEGMENTS-1:0] sel_n;
    logic [CNT_W-1:0]        cnt_n;

    // Next state and loop indices; abort overrides everything outside IDLE.
    always_comb begin
        state_n = state;
        seg_n   = im_seg;
        grp_n   = im_group;
        wcnt_n  = wcnt;
        fin     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_FETCH;
                    seg_n   = '0;
                    grp_n   = '0;
                end
            end
            S_FETCH: begin
                if (FETCH_LAT > 1) begin
                    state_n = S_WAIT;
                    wcnt_n  = WAIT_INIT;
                end else begin
                    state_n = S_LOAD;
                end
            end
            S_WAIT: begin
                if (wcnt == 4'd0) begin
                    state_n = S_LOAD;
                end else begin
                    wcnt_n = wcnt - 4'd1;
                end
            end
            S_LOAD: begin
                state_n = S_HOLD;
            end
            S_HOLD: begin
                if (lvl_ready) begin
                    state_n = S_FETCH;
                    if (im_group == GRP_LAST) begin
                        grp_n = '0;
                        if (im_seg == SEG_LAST) begin
                            seg_n   = '0;
                            state_n = S_IDLE;
                            fin     = 1'b1;
                        end else begin
                            seg_n = im_seg + SEG_W'(1);
                        end
                    end else begin
                        grp_n = im_group + GRP_W'(1);
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        if (abort && (state != S_IDLE)) begin
            state_n = S_IDLE;
            seg_n   = '0;
            grp_n   = '0;
            wcnt_n  = '0;
            fin     = 1'b0;
        end
    end

    // Next values of the one-hot select and the group's valid-feature count.
    always_comb begin
        sel_n = '0;
        cnt_n = '0;
        if (state_n == S_LOAD) begin
            sel_n[seg_n] = 1'b1;
        end
        if (state_n != S_IDLE) begin
            cnt_n = (grp_n == GRP_LAST) ? CNT_W'(LAST_CNT)
                                        : CNT_W'(FEATURES_PER_CC);
        end
    end

    // State, counters and all outputs registered from the next-state view.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            wcnt           <= '0;
            im_seg         <= '0;
            im_group       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            im_req         <= 1'b0;
            seg_sel        <= '0;
            qtz_out_reg_en <= 1'b0;
            grp_valid_cnt  <= '0;
            lvl_valid      <= 1'b0;
        end else begin
            state          <= state_n;
            wcnt           <= wcnt_n;
            im_seg         <= seg_n;
            im_group       <= grp_n;
            busy           <= (state_n != S_IDLE);
            done           <= fin;
            im_req         <= (state_n == S_FETCH);
            seg_sel        <= sel_n;
            qtz_out_reg_en <= (state_n == S_LOAD);
            grp_valid_cnt  <= cnt_n;
            lvl_valid      <= (state_n == S_HOLD);
        end
    end

endmodule
